// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
// Shared types for the cache-to-memory arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, MEM_I, MEM_D, DONE)
//   arb_port_t  : identifies the requesting cache port (PORT_I, PORT_D)
//   other_port  : helper that returns the port opposite to its argument
package cache_mem_arbiter_pkg;

    localparam int ARB_WORD_W = 8;
    localparam int ARB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin picker.
//   req_i[1:0]     : request vector, bit 0 = instruction port, bit 1 = data port
//   last_grant_i   : port serviced most recently
//   grant_o[1:0]   : one-hot grant, same bit order as req_i
//   grant_valid_o  : high when any port is granted
module rr_arb2
    import cache_mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_port_t  last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_valid_o
);

    // On a tie the port that was not serviced last wins, which makes
    // continuously requesting ports alternate strictly.
    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (other_port(last_grant_i) == PORT_I) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    assign grant_valid_o = |req_i;

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Serialises instruction-cache fills and data-cache fills/writebacks onto a
// single main-memory port, one transaction at a time, with round-robin
// fairness between the two caches.
//   clock, reset_n                    : clock and async active-low reset
//   i_req/i_addr -> i_done/i_rdata    : instruction cache read port
//   d_req/d_we/d_addr/d_wdata
//                -> d_done/d_rdata    : data cache read/write port
//   mem_req/mem_we/mem_addr/mem_wdata
//                <- mem_ready/mem_rdata : main-memory port
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int WORD_W = ARB_WORD_W,
    parameter int ADDR_W = ARB_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [WORD_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_done,
    output logic [WORD_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata
);

    arb_state_t        state_q,      state_d;
    arb_port_t         last_grant_q, last_grant_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [WORD_W-1:0] wdata_q,      wdata_d;
    logic [WORD_W-1:0] i_rdata_q,    i_rdata_d;
    logic [WORD_W-1:0] d_rdata_q,    d_rdata_d;

    logic [1:0]        grant;
    logic              grant_valid;

    rr_arb2 u_rr_arb2 (
        .req_i         ({d_req, i_req}),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // Next-state logic. Requests are only looked at in IDLE, so a request
    // still held during DONE is never re-granted. last_grant is updated when
    // memory completes, which means in DONE it names the port to signal.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant[0]) begin
                        state_d = MEM_I;
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                    end else begin
                        state_d = MEM_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end
                end
            end

            MEM_I, MEM_D: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        if (state_q == MEM_I) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    last_grant_d = (state_q == MEM_I) ? PORT_I : PORT_D;
                    state_d      = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding registers; the async reset abandons any in-flight transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // mem_req is decoded straight from the state register so that an
    // asynchronous reset drops it immediately, without waiting for a clock.
    assign mem_req   = (state_q == MEM_I) || (state_q == MEM_D);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign i_done    = (state_q == DONE) && (last_grant_q == PORT_I);
    assign d_done    = (state_q == DONE) && (last_grant_q == PORT_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed bench for cache_mem_arbiter. Expected transactions are queued as
// requests are issued; a monitor checks the memory-side request against the
// queue head and pops it when the matching done pulse appears.
module tb_cache_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [7:0]  i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_done;
    logic [7:0]  d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    txn_t        sb[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          waitStates = 0;
    int          cyc        = 0;
    int          lastDoneCyc = 0;
    int          reqCycles  = 0;
    int          memCnt     = 0;
    bit          abortFlag  = 0;
    bit          armGap     = 0;
    logic        prevIDone  = 0;
    logic        prevDDone  = 0;
    logic        prevReq    = 0;
    logic [7:0]  iModel     = 8'h00;
    logic [7:0]  dModel     = 8'h00;

    cache_mem_arbiter #(.WORD_W(8), .ADDR_W(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] memData(input logic [31:0] a);
        return a[7:0] ^ 8'hE5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expectTxn(input logic port, input logic we, input logic [31:0] addr, input logic [7:0] wdata);
        txn_t t;
        t.port  = port;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        sb.push_back(t);
    endtask

    // Issue one request, hold it until done is seen, then drop it on the
    // following rising edge.
    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr, input logic [7:0] wdata);
        bit got;
        if (port == 1'b0) begin
            i_addr = addr;
            i_req  = 1'b1;
        end else begin
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
            d_req   = 1'b1;
        end
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clock);
            got = (port == 1'b0) ? i_done : d_done;
        end
        if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        if (port == 1'b0) i_req = 1'b0;
        else              d_req = 1'b0;
    endtask

    // Memory model: answers after waitStates cycles of mem_req.
    always @(negedge clock) begin
        if (mem_req) begin
            if (memCnt >= waitStates) begin
                mem_ready = 1'b1;
                mem_rdata = mem_we ? 8'hFF : memData(mem_addr);
                memCnt    = 0;
            end else begin
                mem_ready = 1'b0;
                memCnt    = memCnt + 1;
            end
        end else begin
            mem_ready = 1'b0;
            memCnt    = 0;
        end
    end

    // Monitor: memory request contents, request length, done ordering/data.
    always @(negedge clock) begin
        txn_t e;
        cyc++;
        if (mem_req) begin
            if (!prevReq && armGap && sb.size() > 0 && sb[0].port == 1'b1) begin
                checkOutput("d_grant_gap", cyc - lastDoneCyc, 32'd2);
                armGap = 0;
            end
            reqCycles++;
            if (sb.size() == 0) begin
                checkOutput("memreq_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("mem_addr", mem_addr, sb[0].addr);
                checkOutput("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                if (sb[0].we) checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, sb[0].wdata});
            end
        end else if (reqCycles != 0) begin
            if (!abortFlag) checkOutput("memreq_len", reqCycles, waitStates + 1);
            reqCycles = 0;
        end
        prevReq = mem_req;

        if (prevIDone) checkOutput("i_done_one_cycle", {31'd0, i_done}, 32'd0);
        if (prevDDone) checkOutput("d_done_one_cycle", {31'd0, d_done}, 32'd0);
        prevIDone = i_done;
        prevDDone = d_done;

        if (i_done || d_done) begin
            checkOutput("dual_done", {31'd0, i_done && d_done}, 32'd0);
            checkOutput("memreq_in_done", {31'd0, mem_req}, 32'd0);
            lastDoneCyc = cyc;
            if (sb.size() == 0) begin
                checkOutput("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("done_port", {31'd0, d_done}, {31'd0, e.port});
                if (e.port == 1'b0) begin
                    iModel = memData(e.addr);
                    checkOutput("i_rdata", {24'd0, i_rdata}, {24'd0, iModel});
                end else begin
                    if (!e.we) dModel = memData(e.addr);
                    checkOutput("d_rdata", {24'd0, d_rdata}, {24'd0, dModel});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        reset_n   = 1'b0;
        i_req     = 1'b0;
        i_addr    = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 8'd0;
        mem_ready = 1'b0;
        mem_rdata = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_mem_req",   {31'd0, mem_req},   32'd0);
        checkOutput("rst_mem_we",    {31'd0, mem_we},    32'd0);
        checkOutput("rst_i_done",    {31'd0, i_done},    32'd0);
        checkOutput("rst_d_done",    {31'd0, d_done},    32'd0);
        checkOutput("rst_mem_addr",  mem_addr,           32'd0);
        checkOutput("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        checkOutput("rst_i_rdata",   {24'd0, i_rdata},   32'd0);
        checkOutput("rst_d_rdata",   {24'd0, d_rdata},   32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] single instruction read, zero wait states");
        waitStates = 0;
        expectTxn(1'b0, 1'b0, 32'h0000_0040, 8'h00);
        applyStimulus(1'b0, 1'b0, 32'h0000_0040, 8'h00);
        checkOutput("i_rdata_A5", {24'd0, i_rdata}, 32'h0000_00A5);

        $display("[TB] data read then writeback with 4 wait states");
        expectTxn(1'b1, 1'b0, 32'h0000_0080, 8'h00);
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, 8'h00);
        waitStates = 4;
        expectTxn(1'b1, 1'b1, 32'h0000_1000, 8'h3C);
        applyStimulus(1'b1, 1'b1, 32'h0000_1000, 8'h3C);
        checkOutput("d_rdata_after_write", {24'd0, d_rdata}, 32'h0000_0065);

        $display("[TB] simultaneous requests alternate");
        waitStates = 0;
        expectTxn(1'b0, 1'b0, 32'h0000_0100, 8'h00);
        expectTxn(1'b1, 1'b0, 32'h0000_0200, 8'h00);
        expectTxn(1'b0, 1'b0, 32'h0000_0104, 8'h00);
        expectTxn(1'b1, 1'b0, 32'h0000_0204, 8'h00);
        fork
            begin
                applyStimulus(1'b0, 1'b0, 32'h0000_0100, 8'h00);
                applyStimulus(1'b0, 1'b0, 32'h0000_0104, 8'h00);
            end
            begin
                applyStimulus(1'b1, 1'b0, 32'h0000_0200, 8'h00);
                applyStimulus(1'b1, 1'b0, 32'h0000_0204, 8'h00);
            end
        join

        $display("[TB] data request arrives during instruction transaction");
        waitStates = 3;
        armGap = 1;
        expectTxn(1'b0, 1'b0, 32'h0000_0300, 8'h00);
        expectTxn(1'b1, 1'b0, 32'h0000_0400, 8'h00);
        fork
            applyStimulus(1'b0, 1'b0, 32'h0000_0300, 8'h00);
            begin
                repeat (2) @(posedge clock);
                #1;
                applyStimulus(1'b1, 1'b0, 32'h0000_0400, 8'h00);
            end
        join
        checkOutput("gap_checked", {31'd0, armGap}, 32'd0);

        $display("[TB] reset asserted mid-transaction");
        waitStates = 20;
        expectTxn(1'b1, 1'b1, 32'h0000_0500, 8'h77);
        d_we    = 1'b1;
        d_addr  = 32'h0000_0500;
        d_wdata = 8'h77;
        d_req   = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = mem_req;
        end
        checkOutput("rst_test_memreq_seen", {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clock);
        #2;
        abortFlag = 1;
        reset_n   = 1'b0;
        #1;
        checkOutput("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
        d_req = 1'b0;
        sb.delete();
        iModel = 8'h00;
        dModel = 8'h00;
        repeat (2) @(negedge clock);
        checkOutput("rst_hold_d_done",  {31'd0, d_done},  32'd0);
        checkOutput("rst_hold_d_rdata", {24'd0, d_rdata}, 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        abortFlag = 0;
        repeat (2) @(negedge clock);
        checkOutput("post_rst_idle", {31'd0, mem_req}, 32'd0);
        @(posedge clock);
        #1;
        waitStates = 1;
        expectTxn(1'b1, 1'b0, 32'h0000_2222, 8'h00);
        applyStimulus(1'b1, 1'b0, 32'h0000_2222, 8'h00);
        checkOutput("post_rst_d_rdata", {24'd0, d_rdata}, 32'h0000_00C7);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clock);
        checkOutput("sb_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
